// File: rtl/ser_pkg.sv
// Shared types and helpers for the ser_tx parallel-to-serial stage.
// State names carry an ST_ prefix so they cannot collide with the GAP
// parameter of the modules that import this package.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_SHIFT_PAR = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  // Level driven on the serial line whenever no frame bit is being sent.
  localparam logic IDLE_LVL = 1'b0;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ser_dncnt.sv
// Loadable down-counter with a terminal-count flag (count == 0).
// Load has priority over decrement; the count never wraps below zero.
module ser_dncnt
  import ser_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count register: clear on reset, load on request, otherwise count down to zero.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && !tc_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ser_tx.sv
// ser_tx: accepts WIDTH-bit words over valid/ready and shifts them out
// MSB-first on x, one bit per clock, followed by GAP idle cycles at x=0.
// Counts completed frames.
// Optional feature macro: SER_TX_PARITY_EN appends an even-parity bit
// (state ST_SHIFT_PAR) after the LSB of each word.
module ser_tx
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             x,
  output logic             busy,
  output logic [CNT_W-1:0] frames
);

  localparam int BW = clog2(WIDTH);
  localparam int GW = clog2(GAP);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit STREAM = (GAP == 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] frames_q, frames_d;
`ifdef SER_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic bit_load, bit_dec, bit_tc;
  logic gap_load, gap_dec, gap_tc;
  logic last_cycle;
  logic frame_end;
  logic accept;

  // Bit counter: WIDTH-1 at accept, reaches zero while the LSB is on x.
  ser_dncnt #(.W(BW)) u_bit_cnt (
    .clk_i      (c),
    .srst_i     (r),
    .load_i     (bit_load),
    .load_val_i (BIT_LOAD),
    .dec_i      (bit_dec),
    .tc_o       (bit_tc)
  );

  // Gap counter: GAP-1 at frame end, reaches zero in the final idle cycle.
  ser_dncnt #(.W(GW)) u_gap_cnt (
    .clk_i      (c),
    .srst_i     (r),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .tc_o       (gap_tc)
  );

  // Final bit cycle of a frame: the LSB, or the parity bit when enabled.
`ifdef SER_TX_PARITY_EN
  assign last_cycle = (state_q == ST_SHIFT_PAR);
`else
  assign last_cycle = (state_q == ST_SHIFT) && bit_tc;
`endif

  // Ready depends only on state and reset, never on din_vld.
  assign din_rdy = !r && ((state_q == ST_IDLE) || (STREAM && last_cycle));
  assign accept  = din_vld && din_rdy;

  // Next-state, shift and counter control.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    x_d       = IDLE_LVL;
    frames_d  = frames_q;
    bit_load  = 1'b0;
    bit_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    frame_end = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (!bit_tc) begin
          sreg_d  = sreg_q << 1;
          x_d     = sreg_d[WIDTH-1];
          bit_dec = 1'b1;
        end else begin
`ifdef SER_TX_PARITY_EN
          state_d = ST_SHIFT_PAR;
          x_d     = par_q;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SER_TX_PARITY_EN
      ST_SHIFT_PAR: begin
        frame_end = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_tc) begin
          state_d = ST_IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_end) begin
      frames_d = frames_q + 1'b1;
      if (!STREAM) begin
        state_d  = ST_GAP;
        gap_load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Accept happens only in IDLE or on the streaming hand-off cycle, so it
    // safely overrides the frame-end transition above.
    if (accept) begin
      sreg_d   = din;
      x_d      = din[WIDTH-1];
      bit_load = 1'b1;
      state_d  = ST_SHIFT;
`ifdef SER_TX_PARITY_EN
      par_d    = ^din;
`endif
    end
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge c) begin
    if (r) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      x_q      <= IDLE_LVL;
      frames_q <= '0;
`ifdef SER_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      x_q      <= x_d;
      frames_q <= frames_d;
`ifdef SER_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign x      = x_q;
  assign frames = frames_q;
  assign busy   = (state_q == ST_SHIFT) || (state_q == ST_SHIFT_PAR) ||
                  (state_q == ST_GAP);

endmodule

// File: tb/tb_ser_tx.sv
// Directed testbench for ser_tx: one instance with GAP=2, one with GAP=0.
// Expected serial bits and ready levels are queued when a word is driven
// and popped cycle by cycle as the DUT shifts.
module tb_ser_tx;

`ifdef SER_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int W = 8;

  typedef struct packed {
    logic x;
    logic rdy;
  } exp_t;

  logic       c = 1'b0;
  logic       r;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic       x_a, x_b;
  logic       busy_a, busy_b;
  logic [15:0] frames_a, frames_b;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  ser_tx #(.WIDTH(8), .GAP(2), .CNT_W(16)) dut_a (
    .c(c), .r(r), .din(din_a), .din_vld(vld_a), .din_rdy(rdy_a),
    .x(x_a), .busy(busy_a), .frames(frames_a)
  );

  ser_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) dut_b (
    .c(c), .r(r), .din(din_b), .din_vld(vld_b), .din_rdy(rdy_b),
    .x(x_b), .busy(busy_b), .frames(frames_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge c);
    #1;
  endtask

  // Queue the x/ready sequence a word should produce, including its gap.
  task automatic push_word(input string who, input logic [7:0] w, input int gap);
    exp_t e;
    $display("%s: word %02h queued (gap %0d)", who, w, gap);
    for (int i = 0; i < W + PB; i++) begin
      e.x   = (i < W) ? w[7-i] : ^w;
      e.rdy = (gap == 0) && (i == W + PB - 1);
      sb.push_back(e);
    end
    for (int g = 0; g < gap; g++) begin
      e.x   = 1'b0;
      e.rdy = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Compare n consecutive frame cycles of one instance against the queue.
  task automatic drain(input int sel, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(sel ? "x_b" : "x_a", sel ? x_b : x_a, e.x);
        chk(sel ? "rdy_b" : "rdy_a", sel ? rdy_b : rdy_a, e.rdy);
        chk(sel ? "busy_b" : "busy_a", sel ? busy_b : busy_a, 1);
      end
      @(posedge c);
      #1;
    end
  endtask

  initial begin
    r = 1'b1; vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;

    // Reset state
    repeat (2) @(posedge c);
    #1;
    chk("rst_rdy_a", rdy_a, 0);
    chk("rst_rdy_b", rdy_b, 0);
    chk("rst_x_a", x_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_frames_a", frames_a, 0);
    chk("rst_frames_b", frames_b, 0);
    r = 1'b0;
    #1;
    chk("post_rst_rdy_a", rdy_a, 1);
    chk("post_rst_rdy_b", rdy_b, 1);

    // Single word B4 on GAP=2 instance
    din_a = 8'hB4; vld_a = 1'b1;
    push_word("a", 8'hB4, 2);
    next();
    vld_a = 1'b0;
    drain(0, W + PB + 2);
    #1;
    chk("b4_rdy_after_gap", rdy_a, 1);
    chk("b4_busy_after", busy_a, 0);
    chk("b4_x_after", x_a, 0);
    chk("b4_frames", frames_a, 1);

    // Stall: FF presented in cycle 3 of a 5A frame, held until accepted
    din_a = 8'h5A; vld_a = 1'b1;
    push_word("a", 8'h5A, 2);
    next();
    vld_a = 1'b0;
    drain(0, 2);
    din_a = 8'hFF; vld_a = 1'b1;
    drain(0, W + PB + 2 - 2);
    #1;
    chk("stall_rdy", rdy_a, 1);
    push_word("a", 8'hFF, 2);
    next();
    vld_a = 1'b0;
    drain(0, W + PB + 2);
    #1;
    chk("stall_frames", frames_a, 3);
    for (int i = 0; i < 3; i++) begin
      next();
      chk("stall_idle_x", x_a, 0);
      chk("stall_idle_busy", busy_a, 0);
    end
    chk("stall_frames_once", frames_a, 3);

    // Back-to-back A5, 3C on GAP=0 instance
    din_b = 8'hA5; vld_b = 1'b1;
    push_word("b", 8'hA5, 0);
    next();
    din_b = 8'h3C;
    push_word("b", 8'h3C, 0);
    drain(1, W + PB);
    vld_b = 1'b0;
    drain(1, W + PB);
    #1;
    chk("b2b_rdy", rdy_b, 1);
    chk("b2b_x_idle", x_b, 0);
    chk("b2b_busy", busy_b, 0);
    chk("b2b_frames", frames_b, 2);

    // Single 01 on GAP=0 instance (parity bit 1 when enabled)
    din_b = 8'h01; vld_b = 1'b1;
    push_word("b", 8'h01, 0);
    next();
    vld_b = 1'b0;
    drain(1, W + PB);
    #1;
    chk("w01_x_idle", x_b, 0);
    chk("w01_rdy", rdy_b, 1);
    chk("w01_busy", busy_b, 0);
    chk("w01_frames", frames_b, 3);

    // Reset mid-frame: FF on GAP=2 instance, reset after 3 bits
    din_a = 8'hFF; vld_a = 1'b1;
    push_word("a", 8'hFF, 2);
    next();
    vld_a = 1'b0;
    drain(0, 3);
    sb.delete();
    r = 1'b1;
    #1;
    chk("mid_rst_rdy_a", rdy_a, 0);
    chk("mid_rst_rdy_b", rdy_b, 0);
    next();
    chk("mid_rst_x_a", x_a, 0);
    chk("mid_rst_busy_a", busy_a, 0);
    chk("mid_rst_frames_a", frames_a, 0);
    chk("mid_rst_frames_b", frames_b, 0);
    chk("mid_rst_rdy_hold", rdy_a, 0);
    next();
    r = 1'b0;
    #1;
    chk("mid_rst_rdy_release", rdy_a, 1);
    for (int i = 0; i < 4; i++) begin
      next();
      chk("mid_rst_no_resume_x", x_a, 0);
      chk("mid_rst_no_resume_busy", busy_a, 0);
    end
    chk("mid_rst_frames_final", frames_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
